fft_ctrl: RTL

Sequencer for the in-place radix-2 DIT FFT. It drives the read side of the FFT data memory and the twiddle ROM, which feed `butterfly` on `fft_rdataa`, `fft_rdatab` and `twiddle`. It also drives the write side that consumes `fft_wdataa` and `fft_wdatab`, with write addresses delayed to match the read and butterfly pipeline. Input samples are already in bit-reversed order in memory before `start`.

---
 rtl/fft_pkg.sv | 28 ++
 rtl/fft_addr_pipe.sv | 41 ++++
 rtl/fft_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and address math for the radix-2 DIT FFT sequencer and its benches.
package fft_pkg;

  localparam int MAX_LOG2N = 12;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} fft_ctrl_state_t;

  typedef struct packed {
    logic [MAX_LOG2N-1:0] addra;
    logic [MAX_LOG2N-1:0] addrb;
    logic [MAX_LOG2N-2:0] tw;
  } bfly_addr_t;

  // Butterfly j of stage s pairs elements half apart inside groups of 2*half.
  function automatic bfly_addr_t bfly_addr(input int log2n, input int s, input int j);
    bfly_addr_t r;
    int half, p, g, a;
    half    = 1 << s;
    p       = j & (half - 1);
    g       = j >> s;
    a       = (g << (s + 1)) | p;
    r.addra = MAX_LOG2N'(a);
    r.addrb = MAX_LOG2N'(a + half);
    r.tw    = (MAX_LOG2N-1)'(p << (log2n - 1 - s));
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_pipe.sv
// DEPTH-cycle delay line carrying {valid, addra, addrb} from the read side to the write side.
module fft_addr_pipe #(
  parameter int DEPTH = 3,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vld_in,
  input  logic [AW-1:0] addra_in,
  input  logic [AW-1:0] addrb_in,
  output logic          vld_out,
  output logic [AW-1:0] addra_out,
  output logic [AW-1:0] addrb_out
);

  logic [DEPTH-1:0]         vld_pipe;
  logic [DEPTH-1:0][AW-1:0] a_pipe;
  logic [DEPTH-1:0][AW-1:0] b_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      a_pipe   <= '0;
      b_pipe   <= '0;
    end else begin
      vld_pipe[0] <= vld_in;
      a_pipe[0]   <= addra_in;
      b_pipe[0]   <= addrb_in;
      for (int k = 1; k < DEPTH; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        a_pipe[k]   <= a_pipe[k-1];
        b_pipe[k]   <= b_pipe[k-1];
      end
    end
  end

  assign vld_out   = vld_pipe[DEPTH-1];
  assign addra_out = a_pipe[DEPTH-1];
  assign addrb_out = b_pipe[DEPTH-1];

endmodule

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIT FFT sequencer: one butterfly read per RUN cycle, writes delayed by PIPE.
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int LOG2N        = 10,
  parameter int MEM_LATENCY  = 1,
  parameter int BFLY_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [LOG2N-1:0]         rd_addra,
  output logic [LOG2N-1:0]         rd_addrb,
  output logic [LOG2N-2:0]         tw_addr,
  output logic                     wr_en,
  output logic [LOG2N-1:0]         wr_addra,
  output logic [LOG2N-1:0]         wr_addrb,
  output logic [$clog2(LOG2N)-1:0] stage
);

  localparam int PIPE   = MEM_LATENCY + BFLY_LATENCY;
  localparam int HALF_N = 1 << (LOG2N - 1);
  localparam int SW     = $clog2(LOG2N);
  localparam int JW     = LOG2N - 1;
  localparam int CW     = $clog2(PIPE + 1);

  fft_ctrl_state_t state_q, state_d;
  logic [JW-1:0]   j_q, j_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   stage_d;
  logic            done_d;
  bfly_addr_t      ba;
  logic            ba_unused;

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    stage_d = stage;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse belongs to the finished run.
        if (start && !done) begin
          state_d = RUN;
          j_d     = '0;
          stage_d = '0;
        end
      end
      RUN: begin
        if (j_q == JW'(HALF_N - 1)) begin
          state_d = DRAIN;
          cnt_d   = CW'(PIPE);
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          if (stage == SW'(LOG2N - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            stage_d = stage + 1'b1;
            j_d     = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Addresses are computed for the upcoming cycle so every output is a flop.
  assign ba        = bfly_addr(LOG2N, int'(stage_d), int'(j_d));
  assign ba_unused = ^ba;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      j_q      <= '0;
      cnt_q    <= '0;
      stage    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      rd_addra <= '0;
      rd_addrb <= '0;
      tw_addr  <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
      stage   <= stage_d;
      busy    <= (state_d != IDLE);
      done    <= done_d;
      rd_en   <= (state_d == RUN);
      if (state_d == RUN) begin
        rd_addra <= ba.addra[LOG2N-1:0];
        rd_addrb <= ba.addrb[LOG2N-1:0];
        tw_addr  <= ba.tw[LOG2N-2:0];
      end
    end
  end

  fft_addr_pipe #(.DEPTH(PIPE), .AW(LOG2N)) u_wr_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld_in   (rd_en),
    .addra_in (rd_addra),
    .addrb_in (rd_addrb),
    .vld_out  (wr_en),
    .addra_out(wr_addra),
    .addrb_out(wr_addrb)
  );

endmodule
